// File: rtl/bram_uart_readback_if.sv
// BRAM read port plus uart_send handshake used by the readback block.
// master = the readback engine, slave = BRAM/uart_send side.
interface bram_uart_readback_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd_en;
  logic [7:0]        ram_rdata;
  logic              uart_tx_busy;
  logic              uart_en;
  logic [7:0]        uart_din;

  modport master (
    output ram_addr, ram_rd_en, uart_en, uart_din,
    input  ram_rdata, uart_tx_busy
  );

  modport slave (
    input  ram_addr, ram_rd_en, uart_en, uart_din,
    output ram_rdata, uart_tx_busy
  );
endinterface

// File: rtl/bram_uart_readback.sv
// Streams a BRAM byte range to uart_send as HDR, LEN_H, LEN_L, data..., CSUM.
// One read per data byte, issued only after the previous byte has left the UART.
module bram_uart_readback #(
  parameter int          ADDR_W   = 14,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [15:0]       byte_count,
  output logic              busy,
  output logic              done,
  bram_uart_readback_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_LO, S_RD, S_RD_WAIT, S_LATCH, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    PH_HDR, PH_LEN_H, PH_LEN_L, PH_DATA, PH_CSUM
  } phase_t;

  state_t            state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [15:0]       cnt_q,   cnt_d;
  logic [7:0]        csum_q,  csum_d;
  logic [7:0]        din_q,   din_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      phase_q <= PH_HDR;
      addr_q  <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      din_q   <= din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    din_d   = din_q;
    case (state_q)
      // DONE has busy low, so a start there is accepted just like in IDLE
      S_IDLE, S_DONE: begin
        if (start) begin
          addr_d  = start_addr;
          cnt_d   = byte_count;
          phase_d = PH_HDR;
          csum_d  = '0;
          din_d   = HDR_BYTE;
          state_d = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND:    if (!bus.uart_tx_busy) state_d = S_WAIT_HI;
      S_WAIT_HI: if (bus.uart_tx_busy)  state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!bus.uart_tx_busy) begin
          // cnt_q still holds the full length until the first LATCH
          case (phase_q)
            PH_HDR: begin
              phase_d = PH_LEN_H;
              din_d   = cnt_q[15:8];
              state_d = S_SEND;
            end
            PH_LEN_H: begin
              phase_d = PH_LEN_L;
              din_d   = cnt_q[7:0];
              state_d = S_SEND;
            end
            PH_LEN_L, PH_DATA: begin
              if (cnt_q != 16'd0) begin
                state_d = S_RD;
              end else begin
                phase_d = PH_CSUM;
                din_d   = csum_q;
                state_d = S_SEND;
              end
            end
            PH_CSUM: state_d = S_DONE;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_RD:      state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = S_LATCH;
      S_LATCH: begin
        din_d   = bus.ram_rdata;
        csum_d  = csum_q + bus.ram_rdata;
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q - 16'd1;
        phase_d = PH_DATA;
        state_d = S_SEND;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign bus.ram_addr  = addr_q;
  assign bus.ram_rd_en = (state_q == S_RD);
  assign bus.uart_en   = (state_q == S_SEND) && !bus.uart_tx_busy;
  assign bus.uart_din  = din_q;

endmodule

// File: doc/bram_uart_readback.md
# bram_uart_readback

Reads a byte range from the shared data-holder block RAM and streams it to the PC over the UART transmitter, framed with a header, a length field and a checksum. It is the read/transmit counterpart of the UART-to-BRAM write path. It sits between the BRAM port it is granted by the top-level address mux and the `uart_send` inputs (`uart_en`, `uart_din`, `uart_tx_busy`). It lets the host verify a downloaded scan frame before the DA, CCD and ACQ generators run.

## Interface
Parameters:
- ADDR_W, 14, BRAM byte-address width.
- HDR_BYTE, 8'hA5, first byte of every reply frame.

Ports:
- sys_clk  in  1  clock; every register is updated on its rising edge.
- sys_rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request pulse. Ignored while busy=1.
- start_addr  in  ADDR_W  first BRAM address; sampled on an accepted start.
- byte_count  in  16  number of data bytes; sampled on an accepted start. 0 is legal.
- ram_addr  out  ADDR_W  BRAM read address, registered.
- ram_rd_en  out  1  high in the cycle ram_addr is valid for a read.
- ram_rdata  in  8  BRAM read data, valid exactly 1 cycle after ram_rd_en.
- uart_tx_busy  in  1  busy flag from uart_send.
- uart_en  out  1  one-cycle send strobe to uart_send.
- uart_din  out  8  byte to send; stable from uart_en until the byte completes.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last byte's transmission completes.

## Operation
- Frame on the wire: HDR_BYTE, byte_count[15:8], byte_count[7:0], then data bytes D0..D(N-1) read from start_addr upward, then CSUM.
- CSUM = (D0 + ... + D(N-1)) mod 256. Header and length bytes are excluded. CSUM is 0x00 when N=0.
- Address arithmetic: ram_addr increments modulo 2^ADDR_W, so 0x3FFF wraps to 0x0000. No error is flagged on wrap.
- Byte counter is 16 bits and counts down. The data phase ends when the remaining count reaches 0.
- States: IDLE, SEND (emit uart_en), WAIT_HI, WAIT_LO, RD, RD_WAIT, LATCH, DONE. The SEND sequencer selects header, len_h, len_l, data or csum via a phase register.
- IDLE: when start=1, load the address, count and phase=HDR, clear the checksum, and go to SEND.
- SEND: when uart_tx_busy=0, assert uart_en for 1 cycle with uart_din set to the phase byte, then go to WAIT_HI.
- WAIT_HI: wait for uart_tx_busy=1.
- WAIT_LO: wait for uart_tx_busy=0, then advance the phase:
  - HDR → LEN_H → LEN_L.
  - After LEN_L or after a data byte: go to RD if the remaining count is nonzero, otherwise go to SEND with phase=CSUM.
  - After CSUM: go to DONE.
- RD: drive ram_addr and ram_rd_en=1 for 1 cycle. Go to RD_WAIT.
- RD_WAIT: 1-cycle wait for the BRAM read latency.
- LATCH: latch ram_rdata into uart_din, add it to the checksum, increment the address, decrement the count, then go to SEND with phase=DATA.
- DONE: pulse done for 1 cycle, drop busy, return to IDLE.
- Data prefetch is not allowed: exactly one BRAM read is issued per data byte, and only after the previous byte has completed.
- A start pulse while busy=1 is dropped. It is not queued.
- Reset mid-operation: the state machine returns to IDLE immediately and all outputs take their reset values. A partial frame is abandoned.

## Timing
- Reset values: ram_addr=0, ram_rd_en=0, uart_en=0, uart_din=0, busy=0, done=0, checksum=0, state=IDLE.
- Start sampled in cycle T:
  - busy=1 from T+1.
  - The first uart_en is at T+1 if uart_tx_busy=0.
- Data byte: ram_rd_en at cycle R, rdata latched at R+2, uart_en no earlier than R+3.
- uart_en is never high while uart_tx_busy=1 and is never high for 2 consecutive cycles.
- uart_din changes only in LATCH or on entry to SEND, never during WAIT_HI or WAIT_LO.
- done is asserted in the cycle after busy falls in the final WAIT_LO. busy falls together with done.
- If uart_tx_busy never rises, the block waits in WAIT_HI indefinitely. The top level guarantees uart_send raises busy within 3 cycles of uart_en.

## Test plan
- BRAM[0x100..0x102]=10,20,30, start_addr=0x100, count=3 → UART bytes A5 00 03 10 20 30 60. Exactly 3 ram_rd_en pulses at 0x100, 0x101, 0x102. One done pulse.
- count=0 → bytes A5 00 00 00. No ram_rd_en. done follows.
- start_addr=0x3FFE, count=4, BRAM=01,02,03,04 at 3FFE,3FFF,0000,0001 → read addresses in that order. CSUM=0A.
- A second start pulse mid-frame with a different address → ignored. The frame and byte count are unchanged.
- uart_tx_busy held high for 200 cycles after the header → no uart_en during the stall. The frame resumes intact afterwards.
- Assert sys_rst_n=0 during a data byte → all outputs at reset values next edge. After release, a new start produces a full correct frame.
